// File: rtl/mul_accumulate.sv
// Accumulates a stream of unsigned products into a running sum and returns
// sum, term count and carry-out flag through a valid/ready handshake, one
// result per sequence terminated by prod_last.
module mul_accumulate #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr,
  input  logic [WIDTH-1:0]     prod,
  input  logic                 prod_valid,
  input  logic                 prod_last,
  output logic                 prod_ready,
  output logic [WIDTH-1:0]     sum,
  output logic [CNT_WIDTH-1:0] sum_count,
  output logic                 sum_ovf,
  output logic                 sum_valid,
  input  logic                 sum_ready
);

  typedef enum logic [0:0] {StAcc, StHold} state_e;

  state_e               state;
  logic [WIDTH-1:0]     acc;
  logic [CNT_WIDTH-1:0] cnt;
  logic                 ovf;

  logic                 beat;
  logic [WIDTH:0]       add_full;
  logic [CNT_WIDTH-1:0] cnt_inc;
  logic                 ovf_next;

  // Handshake decode, widened add (top bit is the carry-out), saturating count
  always_comb begin
    prod_ready = (state == StAcc) && !clr;
    beat       = prod_valid && prod_ready;
    add_full   = {1'b0, acc} + {1'b0, prod};
    ovf_next   = ovf | add_full[WIDTH];
    cnt_inc    = (cnt == {CNT_WIDTH{1'b1}}) ? cnt : cnt + CNT_WIDTH'(1);
  end

  // Accumulator FSM with registered result outputs; clr overrides everything
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= StAcc;
      acc       <= '0;
      cnt       <= '0;
      ovf       <= 1'b0;
      sum       <= '0;
      sum_count <= '0;
      sum_ovf   <= 1'b0;
      sum_valid <= 1'b0;
    end else if (clr) begin
      // Result data is deliberately kept; only the pending handshake is dropped
      state     <= StAcc;
      acc       <= '0;
      cnt       <= '0;
      ovf       <= 1'b0;
      sum_valid <= 1'b0;
    end else begin
      unique case (state)
        StAcc: begin
          if (beat) begin
            if (prod_last) begin
              sum       <= add_full[WIDTH-1:0];
              sum_count <= cnt_inc;
              sum_ovf   <= ovf_next;
              sum_valid <= 1'b1;
              acc       <= '0;
              cnt       <= '0;
              ovf       <= 1'b0;
              state     <= StHold;
            end else begin
              acc <= add_full[WIDTH-1:0];
              cnt <= cnt_inc;
              ovf <= ovf_next;
            end
          end
        end
        StHold: begin
          if (sum_valid && sum_ready) begin
            sum_valid <= 1'b0;
            state     <= StAcc;
          end
        end
        default: state <= StAcc;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_accumulate.sv
// Directed plus randomized bench for mul_accumulate; expected results come
// from a plain-arithmetic model of each product sequence.
module tb_mul_accumulate;

  logic        clk;
  logic        rst_n;
  logic        clr;
  logic [31:0] prod;
  logic        prod_valid;
  logic        prod_last;
  logic        prod_ready;
  logic [31:0] sum;
  logic [15:0] sum_count;
  logic        sum_ovf;
  logic        sum_valid;
  logic        sum_ready;

  int n_cmp;
  int n_err;
  logic [31:0] seq_q[$];

  mul_accumulate #(
    .WIDTH    (32),
    .CNT_WIDTH(16)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .prod      (prod),
    .prod_valid(prod_valid),
    .prod_last (prod_last),
    .prod_ready(prod_ready),
    .sum       (sum),
    .sum_count (sum_count),
    .sum_ovf   (sum_ovf),
    .sum_valid (sum_valid),
    .sum_ready (sum_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive seq_q as back-to-back beats; returns at the negedge after the final beat.
  task automatic send(input bit with_last);
    for (int i = 0; i < seq_q.size(); i++) begin
      @(negedge clk);
      prod       = seq_q[i];
      prod_valid = 1'b1;
      prod_last  = with_last && (i == seq_q.size() - 1);
      #1;
      check("beat_ready", {63'd0, prod_ready}, 64'd1);
    end
    @(negedge clk);
    prod_valid = 1'b0;
    prod_last  = 1'b0;
  endtask

  // Reference: true sum of all terms; carry-out seen iff the true sum reaches 2^32.
  task automatic expect_result(input string tag);
    longint unsigned total;
    longint unsigned n;
    total = 0;
    foreach (seq_q[i]) total += longint'(seq_q[i]);
    n = seq_q.size();
    if (n > 65535) n = 65535;
    check({tag, "_valid"}, {63'd0, sum_valid}, 64'd1);
    check({tag, "_sum"}, {32'd0, sum}, total & 64'hFFFF_FFFF);
    check({tag, "_count"}, {48'd0, sum_count}, n);
    check({tag, "_ovf"}, {63'd0, sum_ovf}, (total >= 64'h1_0000_0000) ? 64'd1 : 64'd0);
    if (sum_ready) begin
      @(negedge clk);
      check({tag, "_valid_drop"}, {63'd0, sum_valid}, 64'd0);
      check({tag, "_ready_back"}, {63'd0, prod_ready}, 64'd1);
    end
  endtask

  initial begin
    n_cmp      = 0;
    n_err      = 0;
    rst_n      = 1'b0;
    clr        = 1'b0;
    prod       = '0;
    prod_valid = 1'b0;
    prod_last  = 1'b0;
    sum_ready  = 1'b1;

    // Reset state
    @(negedge clk);
    check("rst_valid", {63'd0, sum_valid}, 64'd0);
    check("rst_sum", {32'd0, sum}, 64'd0);
    check("rst_count", {48'd0, sum_count}, 64'd0);
    check("rst_ovf", {63'd0, sum_ovf}, 64'd0);
    check("rst_ready", {63'd0, prod_ready}, 64'd1);
    rst_n = 1'b1;

    // Basic three-term sequence
    seq_q = '{32'd2, 32'd7304, 32'd46};
    send(1'b1);
    expect_result("basic");

    // Single max-value term
    seq_q = '{32'hFFFF_FFFF};
    send(1'b1);
    expect_result("single_max");

    // Wrap sets ovf; the next sequence starts clean
    seq_q = '{32'hFFFF_FFFF, 32'd2};
    send(1'b1);
    expect_result("wrap");
    seq_q = '{32'd3};
    send(1'b1);
    expect_result("after_wrap");

    // Backpressure: result held for 5 cycles while a term waits
    sum_ready = 1'b0;
    seq_q = '{32'd10, 32'd20};
    send(1'b1);
    expect_result("hold");
    prod       = 32'd99;
    prod_valid = 1'b1;
    prod_last  = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check("hold_valid", {63'd0, sum_valid}, 64'd1);
      check("hold_sum", {32'd0, sum}, 64'd30);
      check("hold_ready", {63'd0, prod_ready}, 64'd0);
    end
    sum_ready = 1'b1;
    @(negedge clk);
    check("hs_valid_drop", {63'd0, sum_valid}, 64'd0);
    check("hs_ready", {63'd0, prod_ready}, 64'd1);
    @(negedge clk);
    prod_valid = 1'b0;
    prod_last  = 1'b0;
    seq_q = '{32'd99};
    expect_result("post_hold");

    // Clear mid-sequence discards partial sum and the concurrent term
    seq_q = '{32'd5, 32'd9};
    send(1'b0);
    clr        = 1'b1;
    prod       = 32'd7;
    prod_valid = 1'b1;
    #1;
    check("clr_ready", {63'd0, prod_ready}, 64'd0);
    @(negedge clk);
    clr        = 1'b0;
    prod_valid = 1'b0;
    check("clr_keep_sum", {32'd0, sum}, 64'd99);
    check("clr_valid", {63'd0, sum_valid}, 64'd0);
    seq_q = '{32'd5, 32'd6};
    send(1'b1);
    expect_result("after_clr");

    // Randomized sequences
    for (int s = 0; s < 8; s++) begin
      int len;
      len = $urandom_range(1, 6);
      seq_q.delete();
      for (int k = 0; k < len; k++) begin
        if ($urandom_range(0, 1) == 0) seq_q.push_back(32'($urandom_range(0, 1000)));
        else seq_q.push_back($urandom);
      end
      send(1'b1);
      expect_result("rand");
    end

    // Asynchronous reset while holding a result
    sum_ready = 1'b0;
    seq_q = '{32'd4, 32'd5};
    send(1'b1);
    expect_result("pre_rst");
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_valid", {63'd0, sum_valid}, 64'd0);
    check("arst_ready", {63'd0, prod_ready}, 64'd1);
    @(negedge clk);
    rst_n     = 1'b1;
    sum_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("arst_no_stale", {63'd0, sum_valid}, 64'd0);
    end

    // Asynchronous reset mid-sequence discards the partial sum
    seq_q = '{32'd100};
    send(1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    seq_q = '{32'd1};
    send(1'b1);
    expect_result("after_mid_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
